// File: rtl/uart_txrx.sv
// uart_txrx: 8N1 asynchronous serial transceiver.
// The TX side serialises a byte loaded by a one-cycle strobe. The RX side
// synchronises the serial input, mid-bit samples a frame and presents the
// byte together with ready, overrun and framing-error status.
// Ports:
//   clk, rst     - system clock (rising edge), asynchronous active-low reset
//   ser_rxd      - serial input, idle high, asynchronous to clk
//   ser_txd      - serial output, idle high, driven straight from a flop
//   txd_ld, din  - load strobe and byte to transmit
//   txd_busy     - high while a TX frame is in flight
//   rxd_ft       - level acknowledge, clears rxd_rdy and rx_ovr
//   rxd_rdy/dout - received byte waiting / last good received byte
//   rx_ovr       - sticky overrun, rx_ferr - one-cycle framing-error pulse
module uart_txrx #(
    parameter int unsigned DIV   = 434,
    parameter int unsigned DIV_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ser_rxd,
    output logic       ser_txd,
    input  logic       txd_ld,
    input  logic [7:0] din,
    output logic       txd_busy,
    input  logic       rxd_ft,
    output logic       rxd_rdy,
    output logic [7:0] dout,
    output logic       rx_ovr,
    output logic       rx_ferr
);

    localparam logic [DIV_W-1:0] BIT_LAST  = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(DIV / 2 - 1);
    localparam logic [DIV_W-1:0] CNT_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] CNT_ZERO  = DIV_W'(0);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    tx_state_e        tx_state_q, tx_state_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;

    logic             rxd_meta_q, s_rxd_q, rxd_prev_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rdy_q, rdy_d;
    logic [7:0]       dout_q, dout_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;
    logic             good_s;

    // TX state register; reset forces the line high so an aborted frame cannot glitch low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= CNT_ZERO;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

    // TX next state; the line level for the next bit slot is computed here and registered.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (txd_ld) begin
                    tx_state_d = TX_START;
                    tx_shift_d = din;
                    tx_cnt_d   = CNT_ZERO;
                    txd_d      = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    txd_d  = 1'b1;
                    busy_d = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = CNT_ZERO;
                    tx_bit_d   = 3'd0;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = CNT_ZERO;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        // Bit 0 of the shift register is the bit currently on the line.
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = TX_IDLE;
                    tx_cnt_d   = CNT_ZERO;
                    busy_d     = 1'b0;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_cnt_d   = CNT_ZERO;
                txd_d      = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    // Two-flop synchroniser plus one history flop for start-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta_q <= 1'b1;
            s_rxd_q    <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= ser_rxd;
            s_rxd_q    <= rxd_meta_q;
            rxd_prev_q <= s_rxd_q;
        end
    end

    // RX state and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= CNT_ZERO;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rdy_q      <= 1'b0;
            dout_q     <= 8'h00;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rdy_q      <= rdy_d;
            dout_q     <= dout_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
        end
    end

    // RX next state: half-bit delay to mid start bit, then one sample per bit period.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        good_s     = 1'b0;
        ferr_d     = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                // Requiring the previous sample high means a stuck-low line never retriggers.
                if (!s_rxd_q && rxd_prev_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = CNT_ZERO;
                end else begin
                    rx_cnt_d = CNT_ZERO;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = CNT_ZERO;
                    rx_bit_d = 3'd0;
                    if (!s_rxd_q) begin
                        rx_state_d = RX_DATA;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_shift_d = {s_rxd_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_state_d = RX_IDLE;
                    if (s_rxd_q) begin
                        good_s = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
                rx_cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Status flags: acknowledge clears, but a byte completing in the same cycle wins.
    always_comb begin
        rdy_d  = rdy_q;
        ovr_d  = ovr_q;
        dout_d = dout_q;
        if (rxd_ft) begin
            rdy_d = 1'b0;
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
        if (good_s) begin
            rdy_d  = 1'b1;
            dout_d = rx_shift_q;
            if (rdy_q && !rxd_ft) begin
                ovr_d = 1'b1;
            end else begin
                ovr_d = ovr_d;
            end
        end else begin
            dout_d = dout_q;
        end
    end

    assign ser_txd  = txd_q;
    assign txd_busy = busy_q;
    assign rxd_rdy  = rdy_q;
    assign dout     = dout_q;
    assign rx_ovr   = ovr_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: tb/tb_uart_txrx.sv
// Self-checking bench for uart_txrx at 16 clocks per bit.
module tb_uart_txrx;

    localparam int DIVB = 16;

    logic       clk;
    logic       rst;
    logic       rxd_drv;
    logic       loop_en;
    logic       rxd_line;
    logic       ser_txd;
    logic       txd_ld;
    logic [7:0] din;
    logic       txd_busy;
    logic       rxd_ft;
    logic       rxd_rdy;
    logic [7:0] dout;
    logic       rx_ovr;
    logic       rx_ferr;

    int total;
    int bad;
    int ferr_seen;

    assign rxd_line = loop_en ? ser_txd : rxd_drv;

    uart_txrx #(.DIV(DIVB), .DIV_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .ser_rxd  (rxd_line),
        .ser_txd  (ser_txd),
        .txd_ld   (txd_ld),
        .din      (din),
        .txd_busy (txd_busy),
        .rxd_ft   (rxd_ft),
        .rxd_rdy  (rxd_rdy),
        .dout     (dout),
        .rx_ovr   (rx_ovr),
        .rx_ferr  (rx_ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every framing-error pulse seen on the output.
    always @(negedge clk) begin
        if (rx_ferr === 1'b1) ferr_seen <= ferr_seen + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       ack_after;
        logic       exp_rdy;
        logic [7:0] exp_dout;
        logic       exp_ovr;
        int         exp_ferr;
    } rx_vec_t;

    rx_vec_t rx_tab[5];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
        end
    endtask

    // Line level k cycles after the load edge, from the 8N1 frame layout.
    function automatic logic exp_txd(input logic [7:0] b, input int k);
        logic [2:0] bi;
        if (k >= 1 && k <= DIVB) return 1'b0;
        if (k > DIVB && k <= 9 * DIVB) begin
            bi = 3'((k - DIVB - 1) / DIVB);
            return b[bi];
        end
        return 1'b1;
    endfunction

    task automatic tx_frame_check(input logic [7:0] b, input int inj, input logic [7:0] b2);
        @(negedge clk);
        txd_ld = 1'b1;
        din    = b;
        for (int k = 1; k <= 10 * DIVB + 15; k++) begin
            @(negedge clk);
            if (k == 1) txd_ld = 1'b0;
            if (k == inj) begin
                txd_ld = 1'b1;
                din    = b2;
            end
            if (inj != 0 && k == inj + 1) txd_ld = 1'b0;
            check("txd", k, 32'(ser_txd), 32'(exp_txd(b, k)));
            check("busy", k, 32'(txd_busy), 32'((k >= 1 && k <= 10 * DIVB) ? 1 : 0));
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd_drv = frame[i];
            repeat (DIVB) @(negedge clk);
        end
        rxd_drv = 1'b1;
    endtask

    task automatic pulse_ft();
        @(negedge clk);
        rxd_ft = 1'b1;
        @(negedge clk);
        rxd_ft = 1'b0;
    endtask

    initial begin
        logic       m_rdy;
        logic       m_ovr;
        logic [7:0] m_dout;
        logic [7:0] rb;
        logic [7:0] tb_byte;
        logic       stp;
        int         f0;
        int         rdy_hits;
        bit         seen;

        total     = 0;
        bad       = 0;
        ferr_seen = 0;
        rst       = 1'b0;
        rxd_drv   = 1'b1;
        loop_en   = 1'b0;
        txd_ld    = 1'b0;
        din       = 8'h00;
        rxd_ft    = 1'b0;

        rx_tab[0] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 0};
        rx_tab[1] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 0};
        rx_tab[2] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 0};
        rx_tab[3] = '{8'h33, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1};
        rx_tab[4] = '{8'h44, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1, 0};

        repeat (3) @(negedge clk);
        check("rst_txd", 0, 32'(ser_txd), 32'd1);
        check("rst_busy", 0, 32'(txd_busy), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("init_rdy", 0, 32'(rxd_rdy), 32'd0);
        check("init_dout", 0, 32'(dout), 32'd0);
        check("init_ovr", 0, 32'(rx_ovr), 32'd0);
        check("init_ferr", 0, 32'(rx_ferr), 32'd0);

        // TX plain frame, then the same frame with an ignored second load.
        tx_frame_check(8'hA5, 0, 8'h00);
        tx_frame_check(8'hA5, 50, 8'hFF);

        // RX vector table.
        for (int i = 0; i < 5; i++) begin
            f0 = ferr_seen;
            send_rx(rx_tab[i].data, rx_tab[i].stop);
            repeat (4) @(negedge clk);
            check("tab_rdy", i, 32'(rxd_rdy), 32'(rx_tab[i].exp_rdy));
            check("tab_dout", i, 32'(dout), 32'(rx_tab[i].exp_dout));
            check("tab_ovr", i, 32'(rx_ovr), 32'(rx_tab[i].exp_ovr));
            check("tab_ferr", i, 32'(ferr_seen - f0), 32'(rx_tab[i].exp_ferr));
            if (rx_tab[i].ack_after) begin
                pulse_ft();
                check("ack_rdy", i, 32'(rxd_rdy), 32'd0);
                check("ack_ovr", i, 32'(rx_ovr), 32'd0);
            end
        end

        // Short low glitch must be rejected silently.
        f0 = ferr_seen;
        @(negedge clk);
        rxd_drv = 1'b0;
        repeat (4) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_ferr", 0, 32'(ferr_seen - f0), 32'd0);
        check("glitch_rdy", 0, 32'(rxd_rdy), 32'd0);
        check("glitch_dout", 0, 32'(dout), 32'h44);

        // Acknowledge held through a frame: the completing byte still sets ready.
        @(negedge clk);
        rxd_ft = 1'b1;
        repeat (2) @(negedge clk);
        seen = 1'b0;
        fork
            send_rx(8'hC7, 1'b1);
            begin
                for (int i = 0; i < 12 * DIVB && !seen; i++) begin
                    @(negedge clk);
                    if (rxd_rdy === 1'b1) begin
                        seen   = 1'b1;
                        rxd_ft = 1'b0;
                    end
                end
                rxd_ft = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        check("setwin_seen", 0, 32'(seen), 32'd1);
        check("setwin_rdy", 0, 32'(rxd_rdy), 32'd1);
        check("setwin_dout", 0, 32'(dout), 32'hC7);
        check("setwin_ovr", 0, 32'(rx_ovr), 32'd0);

        // Randomised concurrent TX and RX against an abstract flag model.
        m_rdy  = 1'b1;
        m_ovr  = 1'b0;
        m_dout = 8'hC7;
        for (int it = 0; it < 12; it++) begin
            rb      = 8'($urandom);
            tb_byte = 8'($urandom);
            stp     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                pulse_ft();
                m_rdy = 1'b0;
                m_ovr = 1'b0;
            end
            f0 = ferr_seen;
            fork
                tx_frame_check(tb_byte, 0, 8'h00);
                send_rx(rb, stp);
            join
            repeat (4) @(negedge clk);
            if (stp) begin
                m_ovr  = m_ovr | m_rdy;
                m_rdy  = 1'b1;
                m_dout = rb;
            end
            check("rnd_rdy", it, 32'(rxd_rdy), 32'(m_rdy));
            check("rnd_dout", it, 32'(dout), 32'(m_dout));
            check("rnd_ovr", it, 32'(rx_ovr), 32'(m_ovr));
            check("rnd_ferr", it, 32'(ferr_seen - f0), stp ? 32'd0 : 32'd1);
        end

        // Loopback frame.
        pulse_ft();
        loop_en = 1'b1;
        f0 = ferr_seen;
        tx_frame_check(8'h5A, 0, 8'h00);
        for (int i = 0; i < 50 && rxd_rdy !== 1'b1; i++) @(negedge clk);
        check("loop_rdy", 0, 32'(rxd_rdy), 32'd1);
        check("loop_dout", 0, 32'(dout), 32'h5A);
        check("loop_ovr", 0, 32'(rx_ovr), 32'd0);
        check("loop_ferr", 0, 32'(ferr_seen - f0), 32'd0);

        // Reset in the middle of a looped-back frame.
        @(negedge clk);
        txd_ld = 1'b1;
        din    = 8'hC3;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) txd_ld = 1'b0;
        end
        check("pre_rst_busy", 0, 32'(txd_busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mrst_txd", 0, 32'(ser_txd), 32'd1);
        check("mrst_busy", 0, 32'(txd_busy), 32'd0);
        check("mrst_rdy", 0, 32'(rxd_rdy), 32'd0);
        check("mrst_dout", 0, 32'(dout), 32'd0);
        check("mrst_ovr", 0, 32'(rx_ovr), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        f0 = ferr_seen;
        rdy_hits = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rxd_rdy === 1'b1) rdy_hits++;
            if (ser_txd !== 1'b1) rdy_hits++;
        end
        check("post_rst_ferr", 0, 32'(ferr_seen - f0), 32'd0);
        check("post_rst_rdy_or_txd", 0, 32'(rdy_hits), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
